// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port instruction memory (fetch vs loader/debug).
// Optional IMEM_ARB_LOCK_EN adds ldr_lock_i, which blocks fetch grants during boot loading.
module imem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_gnt_o,
  output logic        fetch_rvalid_o,
  output logic [31:0] fetch_rdata_o,
  input  logic        flush_i,
`ifdef IMEM_ARB_LOCK_EN
  input  logic        ldr_lock_i,
`endif
  input  logic        ldr_req_i,
  input  logic        ldr_we_i,
  input  logic [31:0] ldr_addr_i,
  input  logic [31:0] ldr_wdata_i,
  output logic        ldr_gnt_o,
  output logic        ldr_rvalid_o,
  output logic [31:0] ldr_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 4;

  logic               lock_c;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [MEM_LAT-1:0] valid_q, valid_d;
  logic [MEM_LAT-1:0] owner_q, owner_d;  // 1 = loader, 0 = fetch
  logic               fetch_win, ldr_win, fin_valid;
  logic               unused_addr_c;

`ifdef IMEM_ARB_LOCK_EN
  assign lock_c = ldr_lock_i;
`else
  assign lock_c = 1'b0;
`endif

  assign unused_addr_c = ^{fetch_addr_i[1:0], ldr_addr_i[1:0]};

  // Grant selection; held off entirely while in reset so every output reads 0.
  always_comb begin
    fetch_win = 1'b0;
    ldr_win   = 1'b0;
    if (rstn_i) begin
      fetch_win = fetch_req_i && !lock_c &&
                  (!ldr_req_i || (starve_q == CNT_W'(STARVE_MAX)));
      ldr_win   = ldr_req_i && !fetch_win;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (lock_c || !fetch_req_i || fetch_win) begin
      starve_d = '0;
    end else if (starve_q < CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  assign fetch_gnt_o = fetch_win;
  assign ldr_gnt_o   = ldr_win;

  always_comb begin
    mem_req_o   = fetch_win || ldr_win;
    mem_we_o    = ldr_win && ldr_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (fetch_win) begin
      mem_addr_o = {fetch_addr_i[31:2], 2'b00};
    end else if (ldr_win) begin
      mem_addr_o  = {ldr_addr_i[31:2], 2'b00};
      mem_wdata_o = ldr_wdata_i;
    end
  end

  // Tag shift: flush squashes fetch-owned entries already in flight, not the one entering.
  always_comb begin
    valid_d    = '0;
    owner_d    = '0;
    valid_d[0] = fetch_win || (ldr_win && !ldr_we_i);
    owner_d[0] = ldr_win;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      valid_d[i] = valid_q[i-1] && !(flush_i && !owner_q[i-1]);
      owner_d[i] = owner_q[i-1];
    end
  end

  assign fin_valid = valid_q[MEM_LAT-1] && !(flush_i && !owner_q[MEM_LAT-1]);

  always_comb begin
    fetch_rvalid_o = fin_valid && !owner_q[MEM_LAT-1];
    ldr_rvalid_o   = fin_valid && owner_q[MEM_LAT-1];
    fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
    ldr_rdata_o    = ldr_rvalid_o ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
      valid_q  <= '0;
      owner_q  <= '0;
    end else begin
      starve_q <= starve_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: three instances (MEM_LAT 1..3) share one stimulus,
// each backed by its own small memory model.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fr, lr, lwe, fl;
  logic [31:0] fa, la, lwd;

  logic        f_gnt [3];
  logic        f_rv  [3];
  logic        l_gnt [3];
  logic        l_rv  [3];
  logic        m_req [3];
  logic        m_we  [3];
  logic [31:0] f_rd  [3];
  logic [31:0] l_rd  [3];
  logic [31:0] m_addr[3];
  logic [31:0] m_wd  [3];
  logic [31:0] m_rd  [3];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem   [64];
    logic [31:0] rpipe [g+1];

    imem_arbiter #(.MEM_LAT(g+1), .STARVE_MAX(4)) u_dut (
      .clk_i         (clk),
      .rstn_i        (rst_n),
      .fetch_req_i   (fr),
      .fetch_addr_i  (fa),
      .fetch_gnt_o   (f_gnt[g]),
      .fetch_rvalid_o(f_rv[g]),
      .fetch_rdata_o (f_rd[g]),
      .flush_i       (fl),
`ifdef IMEM_ARB_LOCK_EN
      .ldr_lock_i    (1'b0),
`endif
      .ldr_req_i     (lr),
      .ldr_we_i      (lwe),
      .ldr_addr_i    (la),
      .ldr_wdata_i   (lwd),
      .ldr_gnt_o     (l_gnt[g]),
      .ldr_rvalid_o  (l_rv[g]),
      .ldr_rdata_o   (l_rd[g]),
      .mem_req_o     (m_req[g]),
      .mem_we_o      (m_we[g]),
      .mem_addr_o    (m_addr[g]),
      .mem_wdata_o   (m_wd[g]),
      .mem_rdata_i   (m_rd[g])
    );

    // Word memory preset to 0xA000_0000 + word index
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (m_req[g] && m_we[g]) begin
        mem[m_addr[g][7:2]] <= m_wd[g];
      end
    end

    always @(posedge clk) begin
      rpipe[0] <= mem[m_addr[g][7:2]];
      for (int i = 1; i <= g; i++) rpipe[i] <= rpipe[i-1];
    end

    assign m_rd[g] = rpipe[g];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, settle, then return for checks
  task automatic cyc(input logic f_r, input logic [31:0] f_a, input logic l_r, input logic l_we,
                     input logic [31:0] l_a, input logic [31:0] l_wd, input logic f_l);
    @(negedge clk);
    fr = f_r; fa = f_a; lr = l_r; lwe = l_we; la = l_a; lwd = l_wd; fl = f_l;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    fr = 1'b1; fa = 32'h8; lr = 1'b1; lwe = 1'b0; la = 32'h20; lwd = 32'h0; fl = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_fgnt",  32'(f_gnt[0]), 32'h0);
    check("rst_lgnt",  32'(l_gnt[0]), 32'h0);
    check("rst_mreq",  32'(m_req[0]), 32'h0);
    check("rst_maddr", m_addr[0], 32'h0);
    check("rst_frv",   32'(f_rv[0]), 32'h0);
    check("rst_lrv",   32'(l_rv[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; fr = 1'b0; lr = 1'b0;
    idle(1);

    // Fetch only, LAT1
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("f1_gnt0",  32'(f_gnt[0]), 32'h1);
    check("f1_addr0", m_addr[0], 32'h8);
    check("f1_req0",  32'(m_req[0]), 32'h1);
    check("f1_we0",   32'(m_we[0]), 32'h0);
    check("f1_rv0",   32'(f_rv[0]), 32'h0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("f1_gnt1",  32'(f_gnt[0]), 32'h1);
    check("f1_rv1",   32'(f_rv[0]), 32'h1);
    check("f1_rd1",   f_rd[0], 32'hA000_0002);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("f1_gnt2",  32'(f_gnt[0]), 32'h1);
    check("f1_align", m_addr[0], 32'h8);
    check("f1_rv2",   32'(f_rv[0]), 32'h1);
    idle(1);
    check("f1_gnt3",  32'(f_gnt[0]), 32'h0);
    check("f1_req3",  32'(m_req[0]), 32'h0);
    check("f1_addr3", m_addr[0], 32'h0);
    check("f1_rv3",   32'(f_rv[0]), 32'h1);
    check("f1_rd3",   f_rd[0], 32'hA000_0002);
    idle(1);
    check("f1_rv4",   32'(f_rv[0]), 32'h0);
    check("f1_rd4",   f_rd[0], 32'h0);
    idle(2);

    // Loader write then fetch readback
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 32'h0000_4237, 1'b0);
    check("w_lgnt",  32'(l_gnt[0]), 32'h1);
    check("w_fgnt",  32'(f_gnt[0]), 32'h0);
    check("w_we",    32'(m_we[0]), 32'h1);
    check("w_wdata", m_wd[0], 32'h0000_4237);
    check("w_addr",  m_addr[0], 32'hC);
    cyc(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("w_fgnt2", 32'(f_gnt[0]), 32'h1);
    check("w_we2",   32'(m_we[0]), 32'h0);
    check("w_lrv1",  32'(l_rv[0]), 32'h0);
    idle(1);
    check("w_frv",   32'(f_rv[0]), 32'h1);
    check("w_frd",   f_rd[0], 32'h0000_4237);
    check("w_lrv2",  32'(l_rv[0]), 32'h0);
    check("w_wd0",   m_wd[0], 32'h0);
    idle(2);

    // Starvation: loader x4 then fetch, repeating
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h4, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      check($sformatf("st_fgnt%0d", i), 32'(f_gnt[0]), (i == 4 || i == 9) ? 32'h1 : 32'h0);
      check($sformatf("st_lgnt%0d", i), 32'(l_gnt[0]), (i == 4 || i == 9) ? 32'h0 : 32'h1);
      check($sformatf("st_addr%0d", i), m_addr[0], (i == 4 || i == 9) ? 32'h4 : 32'h20);
    end
    // Dropping fetch_req clears the starve count
    for (int i = 0; i < 8; i++) begin
      cyc(i != 2, 32'h4, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      check($sformatf("sc_fgnt%0d", i), 32'(f_gnt[0]), (i == 7) ? 32'h1 : 32'h0);
    end
    idle(4);

    // Flush with three fetches in flight
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("fl_rv0_c1", 32'(f_rv[0]), 32'h1);
    check("fl_rd0_c1", f_rd[0], 32'hA000_0004);
    cyc(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("fl_gnt2",   32'(f_gnt[2]), 32'h1);
    check("fl_rv0_c2", 32'(f_rv[0]), 32'h0);
    check("fl_rv1_c2", 32'(f_rv[1]), 32'h0);
    idle(1);
    check("fl_rv0_c3", 32'(f_rv[0]), 32'h1);
    check("fl_rd0_c3", f_rd[0], 32'hA000_0006);
    check("fl_rv2_c3", 32'(f_rv[2]), 32'h0);
    idle(1);
    check("fl_rv2_c4", 32'(f_rv[2]), 32'h0);
    idle(1);
    check("fl_rv2_c5", 32'(f_rv[2]), 32'h1);
    check("fl_rd2_c5", f_rd[2], 32'hA000_0006);
    idle(1);
    check("fl_rv2_c6", 32'(f_rv[2]), 32'h0);

    // Flush leaves loader entries alone
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("fll_rv0", 32'(l_rv[0]), 32'h1);
    check("fll_rd0", l_rd[0], 32'hA000_0009);
    idle(1);
    check("fll_rv1", 32'(l_rv[1]), 32'h1);
    check("fll_rd1", l_rd[1], 32'hA000_0009);
    idle(2);

    // Mixed owners, LAT2
    cyc(1'b0, 32'h0,  1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0);
    cyc(1'b0, 32'h0,  1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("mx_lrv_c2", 32'(l_rv[1]), 32'h1);
    check("mx_lrd_c2", l_rd[1], 32'hA000_0004);
    check("mx_frv_c2", 32'(f_rv[1]), 32'h0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0);
    check("mx_frv_c3", 32'(f_rv[1]), 32'h1);
    check("mx_frd_c3", f_rd[1], 32'hA000_0005);
    check("mx_lrv_c3", 32'(l_rv[1]), 32'h0);
    idle(1);
    check("mx_lrv_c4", 32'(l_rv[1]), 32'h1);
    check("mx_lrd_c4", l_rd[1], 32'hA000_0004);
    check("mx_frv_c4", 32'(f_rv[1]), 32'h0);
    idle(1);
    check("mx_frv_c5", 32'(f_rv[1]), 32'h1);
    check("mx_frd_c5", f_rd[1], 32'hA000_0005);
    check("mx_lrv_c5", 32'(l_rv[1]), 32'h0);
    idle(1);
    check("mx_frv_c6", 32'(f_rv[1]), 32'h0);
    check("mx_lrv_c6", 32'(l_rv[1]), 32'h0);
    idle(2);

    // Reset with reads in flight
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_fgnt2", 32'(f_gnt[2]), 32'h0);
    check("mr_mreq2", 32'(m_req[2]), 32'h0);
    check("mr_addr2", m_addr[2], 32'h0);
    check("mr_frv1",  32'(f_rv[1]), 32'h0);
    check("mr_frd1",  f_rd[1], 32'h0);
    check("mr_frv0",  32'(f_rv[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; fr = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mr_post_rv1_%0d", i), 32'(f_rv[1]), 32'h0);
      check($sformatf("mr_post_rv2_%0d", i), 32'(f_rv[2]), 32'h0);
      idle(1);
    end
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("mr_new_gnt", 32'(f_gnt[0]), 32'h1);
    idle(1);
    check("mr_new_rv",  32'(f_rv[0]), 32'h1);
    check("mr_new_rd",  f_rd[0], 32'hA000_0002);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write).
- Sits between fetch/loader and the imem.
- Issues at most one memory access per cycle and tracks in-flight accesses through a MEM_LAT-deep tag pipeline.
- Routes each read response back to its owner; supports fetch flush on redirect.

Parameters:
- MEM_LAT, 1, cycles from mem_req_o to valid mem_rdata_i; legal range 1..4.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- fetch_req_i  in  1  fetch read request
- fetch_addr_i  in  32  fetch byte address
- fetch_gnt_o  out  1  fetch request accepted this cycle
- fetch_rvalid_o  out  1  fetch read data valid
- fetch_rdata_o  out  32  fetch read data
- flush_i  in  1  squash all in-flight fetch responses
- ldr_req_i  in  1  loader request
- ldr_we_i  in  1  loader write enable
- ldr_addr_i  in  32  loader byte address
- ldr_wdata_i  in  32  loader write data
- ldr_gnt_o  out  1  loader request accepted this cycle
- ldr_rvalid_o  out  1  loader read data valid (reads only)
- ldr_rdata_o  out  32  loader read data
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  word-aligned address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid MEM_LAT cycles after mem_req_o

Behaviour:
- Single clock; reset asynchronous, active-low.
- Reset values: all outputs 0. Tag pipeline cleared. Starve counter = 0.
- Grant is combinational from the current-cycle requests; at most one grant per cycle.
- A request is accepted in the cycle its gnt is 1. A requester must hold req and its address/data stable until granted.
- Arbitration:
  - Loader has priority over fetch.
  - If starve_cnt == STARVE_MAX and fetch_req_i = 1, fetch wins instead.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when fetch_req_i = 1 and fetch is not granted.
  - Clears when fetch is granted or fetch_req_i = 0.
- Memory drive:
  - mem_req_o = any grant.
  - mem_addr_o = {addr[31:2], 2'b00} of the winner; addr[1:0] are ignored.
  - mem_we_o = ldr_we_i & ldr_gnt_o.
  - mem_wdata_o = ldr_wdata_i.
  - With no grant, mem_addr_o, mem_we_o and mem_wdata_o are 0.
- Tag pipeline: MEM_LAT stages of {valid, owner}. A granted read enters stage 0 (valid = 1, owner = fetch/loader). Writes enter with valid = 0.
- At the final stage:
  - valid & owner = fetch gives fetch_rvalid_o = 1 and fetch_rdata_o = mem_rdata_i.
  - valid & owner = loader gives ldr_rvalid_o = 1 and ldr_rdata_o = mem_rdata_i.
  - rdata outputs are 0 when their rvalid is 0.
- Throughput: back-to-back grants every cycle. Response order equals grant order.
- flush_i:
  - Clears valid on every in-flight fetch-owned stage, including the final stage, so fetch_rvalid_o = 0 in the flush cycle.
  - A fetch granted in the same cycle as flush_i is NOT squashed.
  - Loader entries are unaffected.
- Reset mid-operation drops all in-flight tags. No response is produced for them.

Optional Feature:
- IMEM_ARB_LOCK_EN
- Defined:
  - Adds input port ldr_lock_i (1 bit).
  - While ldr_lock_i = 1, fetch_gnt_o is forced to 0 regardless of starve state, and the starve counter is held at 0.
  - Used during boot-time program loading.
- Undefined: no ldr_lock_i port; arbitration exactly as above.

Test Plan:
- Fetch only, MEM_LAT = 1: fetch_req_i = 1, addr 0x8 for 3 cycles.
  - Required: fetch_gnt_o = 1 each cycle; mem_addr_o = 0x8.
  - Required: fetch_rvalid_o = 1 one cycle later with fetch_rdata_o = mem_rdata_i.
- Loader write, then fetch: ldr write 0x00004237 to addr 0xC, then fetch addr 0xC.
  - Required: mem_we_o = 1 only in the write cycle.
  - Required: fetch read returns 0x00004237.
  - Required: ldr_rvalid_o stays 0.
- Starvation, STARVE_MAX = 4: both requesters held high.
  - Required: loader granted 4 cycles, fetch granted on cycle 5, then loader resumes; the pattern repeats.
- Flush, MEM_LAT = 3: fetch grants at cycles 0, 1, 2 with flush_i in cycle 2.
  - Required: responses for cycles 0 and 1 are suppressed; the cycle-2 response is delivered at cycle 5.
- Mixed owners, MEM_LAT = 2: alternating loader read 0x10 and fetch read 0x14.
  - Required: each rvalid pulses on the correct port in grant order, with matching data.
- Reset mid-flight: assert rstn_i low while 2 reads are in flight.
  - Required: all outputs 0 immediately; no rvalid after release until new grants.
